rez_to_bcd: RTL and testbench

//  Downstream stage of the arithmetic units (power, mul, add...). Takes one signed 28-bit result plus
//  its overflow flag and converts it into 8 BCD digits, a sign flag and an error flag for the 7-seg driver.

---
 rtl/calc_pkg.sv | 17 +
 rtl/bcd_dig_adj.sv | 14 +
 rtl/rez_to_bcd.sv | 152 +++++++++++++++
 tb/tb_rez_to_bcd.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the arithmetic stages and the display path.
package calc_pkg;

    localparam int unsigned W        = 28;
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned CNT_W    = $clog2(W);
    localparam int unsigned SR_W     = 4 * DIGITS + W;
    localparam logic [W-1:0] MAX_DISP = W'(99999999);
    localparam logic [3:0]  ERR_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_dig_adj.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module bcd_dig_adj (
    input  logic [3:0] dig_in,
    output logic [3:0] dig_out
);

    always_comb begin
        dig_out = dig_in;
        if (dig_in >= 4'd5) begin
            dig_out = dig_in + 4'd3;
        end
    end

endmodule

// File: rtl/rez_to_bcd.sv
// Signed result to 8-digit BCD converter, iterative double-dabble, one shift per clock.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module rez_to_bcd
    import calc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          d_in,
    input  logic                  ovr_in,
    input  logic                  valid_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  err,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  valid_out
);

    state_t               state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_r_q, neg_r_d;
    logic                 err_r_q, err_r_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 neg_q, neg_d;
    logic                 err_q, err_d;
    logic                 valid_out_q, valid_out_d;
    logic [W-1:0]         mag;
    logic [4*DIGITS-1:0]  bcd_adj;

    // Two's complement magnitude; -2**(W-1) wraps to 2**(W-1) and fails the range check.
    assign mag = d_in[W-1] ? (~d_in + W'(1)) : d_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_dig_adj u_adj (
            .dig_in  (sr_q[W+4*g +: 4]),
            .dig_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        neg_r_d     = neg_r_q;
        err_r_d     = err_r_q;
        bcd_d       = bcd_q;
        neg_d       = neg_q;
        err_d       = err_q;
        valid_out_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    neg_r_d = d_in[W-1];
                    if (ovr_in || (mag > MAX_DISP)) begin
                        err_r_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_r_d = 1'b0;
                        sr_d    = {{(4*DIGITS){1'b0}}, mag};
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = {bcd_adj[4*DIGITS-2:0], sr_q[W-1:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_out_d = 1'b1;
                state_d     = IDLE;
                if (err_r_q) begin
                    bcd_d = {DIGITS{ERR_DIGIT}};
                    neg_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    bcd_d = sr_q[SR_W-1 -: 4*DIGITS];
                    neg_d = neg_r_q;
                    err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            neg_r_q     <= 1'b0;
            err_r_q     <= 1'b0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            neg_r_q     <= neg_r_d;
            err_r_q     <= err_r_d;
            bcd_q       <= bcd_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            valid_out_q <= valid_out_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Blank every digit above the most significant non-zero one; units always shown.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_d = blank_q;
        if (state_q == DONE) begin
            blank_d = '0;
            if (!err_r_q) begin
                for (int k = DIGITS - 1; k >= 1; k--) begin
                    seen       = seen | (sr_q[W+4*k +: 4] != 4'd0);
                    blank_d[k] = ~seen;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign bcd       = bcd_q;
    assign neg       = neg_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_rez_to_bcd.sv
// Scoreboard bench for rez_to_bcd: directed vectors, monitor checks every valid_out pulse.
module tb_rez_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] d_in;
    logic        ovr_in;
    logic        valid_in;
    logic [31:0] bcd;
    logic        neg;
    logic        err;
    logic [7:0]  blank;
    logic        busy;
    logic        valid_out;

    typedef struct {
        logic [31:0] bcd;
        logic        neg;
        logic        err;
        logic [7:0]  blank;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rez_to_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .ovr_in    (ovr_in),
        .valid_in  (valid_in),
        .bcd       (bcd),
        .neg       (neg),
        .err       (err),
        .blank     (blank),
        .busy      (busy),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_blank(input logic [31:0] b);
        logic [7:0] m;
        logic       seen;
        m    = 8'h00;
        seen = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 7; k >= 1; k--) begin
            if (b[4*k +: 4] != 4'd0) seen = 1'b1;
            m[k] = ~seen;
        end
`endif
        return m;
    endfunction

    // Monitor: every valid_out pulse must match the oldest expectation, on the expected cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out: got bcd %0h at cycle %0d, expected none",
                         bcd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 64'(bcd), 64'(e.bcd));
                check("neg", 64'(neg), 64'(e.neg));
                check("err", 64'(err), 64'(e.err));
                check("blank", 64'(blank), 64'(e.blank));
                check("latency", 64'(cyc), 64'(e.cyc));
                check("busy_at_valid", 64'(busy), 64'd0);
            end
        end
    end

    task automatic send(input logic [27:0] d, input logic ovr, input logic [31:0] eb,
                        input logic en, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        e.bcd   = eb;
        e.neg   = en;
        e.err   = ee;
        e.blank = ee ? 8'h00 : exp_blank(eb);
        e.cyc   = cyc + (ee ? 2 : 30);
        sb.push_back(e);
        d_in     = d;
        ovr_in   = ovr;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        ovr_in   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"}, 64'(bcd), 64'd0);
        check({tag, "_neg"}, 64'(neg), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_blank"}, 64'(blank), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    endtask

    initial begin
        rst      = 1'b0;
        d_in     = '0;
        ovr_in   = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        send(28'd12345678, 1'b0, 32'h12345678, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("busy_in_conv", 64'(busy), 64'd1);
        drain();
        send(28'hFFFFFD6, 1'b0, 32'h00000042, 1'b1, 1'b0);
        drain();
        send(28'hFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();
        send(28'd100000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();
        send(28'h8000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();
        send(28'd99999999, 1'b0, 32'h99999999, 1'b0, 1'b0);
        drain();
        send(-28'sd99999999, 1'b0, 32'h99999999, 1'b1, 1'b0);
        drain();
        send(-28'sd100000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();
        send(28'd0, 1'b0, 32'h00000000, 1'b0, 1'b0);
        drain();
        send(28'hFFFFFFF, 1'b0, 32'h00000001, 1'b1, 1'b0);
        drain();
        send(28'd10000000, 1'b0, 32'h10000000, 1'b0, 1'b0);
        drain();

        // Outputs hold between pulses.
        repeat (5) @(posedge clk);
        #1;
        check("hold_bcd", 64'(bcd), 64'h10000000);

        // Second request while converting is dropped.
        send(28'd12345678, 1'b0, 32'h12345678, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        d_in     = 28'd777;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        drain();
        repeat (40) @(posedge clk);

        // Reset mid-conversion: no result, outputs cleared.
        @(posedge clk);
        #1;
        d_in     = 28'd55555;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);

        send(28'd87654321, 1'b0, 32'h87654321, 1'b0, 1'b0);
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
